mux_nch_rr: RTL

- Parametrised N-channel, W-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Two modes:
  - Fixed-select: a direct generalisation of the 8:1 bit mux.
  - Round-robin scan: fair arbitration across channels.
- Sits between multi-channel sources and a single downstream consumer. Adds one cycle of latency and supports full throughput.

---
 rtl/mux_nch_rr.sv | 118 +++++++++++
 1 files changed

// File: rtl/mux_nch_rr.sv
// N-channel, W-bit multiplexer with a registered output stage, valid/ready handshakes,
// and either fixed-select or round-robin channel choice.
module mux_nch_rr #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_chan,
    output logic              out_valid,
    input  logic              out_ready
);

    // Handshake: a word moves on any interface only in a cycle where valid and
    // ready are both high at the rising edge; ready never waits on the edge itself.

    localparam logic [SEL_W:0]   N_CH_L = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_CH - 1);

    logic [W-1:0]     r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_sel_ok;
    logic             w_fix_valid;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_ok;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_grant;
    logic [W-1:0]     w_gnt_data;
    logic [N_CH-1:0]  w_ready;

    assign w_load_en = !r_out_valid || out_ready;

    // Out-of-range select values only exist when N_CH is not a power of two.
    generate
        if (N_CH == (1 << SEL_W)) begin : g_sel_full
            assign w_sel_ok = 1'b1;
        end else begin : g_sel_part
            assign w_sel_ok = ({1'b0, sel} < N_CH_L);
        end
    endgenerate

    assign w_fix_valid = w_sel_ok && in_valid[sel];

    // First valid channel at or after r_ptr, wrapping at N_CH.
    always_comb begin : rr_search
        logic [SEL_W:0] idx;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        idx        = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, r_ptr} + (SEL_W+1)'(i);
            if (idx >= N_CH_L) begin
                idx = idx - N_CH_L;
            end
            if (!w_rr_found && in_valid[idx[SEL_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = idx[SEL_W-1:0];
            end
        end
    end

    assign w_gnt_ok  = mode ? w_rr_found : w_fix_valid;
    assign w_gnt_idx = mode ? w_rr_idx   : sel;
    assign w_grant   = w_load_en && w_gnt_ok && !rst;

    always_comb begin
        w_gnt_data = '0;
        w_ready    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_gnt_idx == SEL_W'(k)) begin
                w_gnt_data = in_data[k*W +: W];
                w_ready[k] = w_grant;
            end
        end
    end

    assign in_ready = w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_grant) begin
            r_out_data  <= w_gnt_data;
            r_out_chan  <= w_gnt_idx;
            r_out_valid <= 1'b1;
        end else if (out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
        end
    end

    // The pointer only advances on round-robin grants, so it survives fixed-mode stretches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant && mode) begin
            r_ptr <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule
